// File: rtl/hack_ram8.sv
// hack_ram8: 8 x WIDTH register file, synchronous write, combinational read.
// Optional HACK_RAM8_PARITY_EN adds per-word even parity and a parity_err output.
module hack_ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  output logic [WIDTH-1:0] out
`ifdef HACK_RAM8_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  always_comb begin
    mem_d = mem_q;
    if (load) mem_d[address] = in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign out = mem_q[address];
`ifdef HACK_RAM8_PARITY_EN
  logic [7:0] par_q;
  logic [7:0] par_d;
  always_comb begin
    par_d = par_q;
    if (load) par_d[address] = ^in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= '0;
    else par_q <= par_d;
  assign parity_err = par_q[address] != ^mem_q[address];
`endif
endmodule

// File: tb/tb_hack_ram8.sv
// tb_hack_ram8: directed self-checking bench for hack_ram8 with a gated, manually ticked clock.
module tb_hack_ram8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic [2:0]  address = '0;
  logic        load = 1'b0;
  logic [15:0] out;
  int tests = 0;
  int fails = 0;
`ifdef HACK_RAM8_PARITY_EN
  logic parity_err;
  hack_ram8 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .in(in), .address(address),
                               .load(load), .out(out), .parity_err(parity_err));
`else
  hack_ram8 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .in(in), .address(address),
                               .load(load), .out(out));
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
`ifdef HACK_RAM8_PARITY_EN
    tests++;
    assert (parity_err === 1'b0) else begin
      fails++;
      $error("FAIL %s_parity: observed %b expected 0", tag, parity_err);
    end
`endif
  endtask

  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic read_at(input logic [2:0] a, input string tag, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    #2;
    for (int i = 0; i < 8; i++) read_at(3'(i), $sformatf("reset_w%0d", i), 16'h0000);
    rst_n = 1'b1;
    #3;
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      in = 16'(i + 1);
      #1;
      tick();
      check($sformatf("fill_w%0d", i), out, 16'(i + 1));
    end
    load = 1'b0;
    in = 16'h0000;
    for (int i = 0; i < 8; i++) read_at(3'(i), $sformatf("readback_w%0d", i), 16'(i + 1));
    in = 16'hFFFF;
    address = 3'd5;
    #1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 8; i++) read_at(3'(i), $sformatf("hold_w%0d", i), 16'(i + 1));
    address = 3'd2;
    in = 16'hBEEF;
    load = 1'b1;
    #1;
    check("no_bypass_w2", out, 16'h0003);
    tick();
    check("overwrite_w2", out, 16'hBEEF);
    load = 1'b0;
    in = 16'h0000;
    read_at(3'd1, "isolate_w1", 16'h0002);
    read_at(3'd3, "isolate_w3", 16'h0004);
    read_at(3'd7, "isolate_w7", 16'h0008);
    address = 3'd3;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_w3", out, 16'h0000);
    address = 3'd4;
    in = 16'h1234;
    load = 1'b1;
    #1;
    tick();
    check("write_in_reset_w4", out, 16'h0000);
    load = 1'b0;
    rst_n = 1'b1;
    #2;
    tick();
    for (int i = 0; i < 8; i++) read_at(3'(i), $sformatf("post_reset_w%0d", i), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hack_ram8.md
Name: hack_ram8

Overview:
- 8-word by 16-bit register file, the smallest RAM tier of the Hack memory hierarchy (RAM8 -> RAM64 -> ...).
- Built from eight 16-bit load-enabled registers, an address decoder and an 8:1 read multiplexer.
- Writes are synchronous on the clock. Reads are asynchronous and combinational from the address.
- Instantiated as the building block of larger RAM tiers and as scratch storage.

Parameters:
- WIDTH, 16, data word width in bits. The Hack integration always uses 16.
- Depth is fixed at 8 words and the address is fixed at 3 bits. Neither is a parameter.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low; clears all eight words to 0.
- in  input  WIDTH  write data.
- address  input  3  word select for both write and read.
- load  input  1  write enable, active-high, sampled on the rising edge of clk.
- out  output  WIDTH  read data = contents of word[address].

Behaviour:
- Storage: word[0..7], each WIDTH bits.
- Reset:
  - rst_n low immediately forces all words to 0, with no clock needed; out reads 0.
  - Reset dominates load and clk.
  - Deassertion takes effect at the next rising edge.
- Write:
  - On a rising edge of clk with rst_n high and load=1: word[address] <= in.
  - Only the addressed word changes; the other seven hold.
- Hold: load=0 at a rising edge leaves all words unchanged, regardless of in and address.
- Read:
  - out = word[address], purely combinational, zero-cycle latency.
  - out follows any change of address immediately, with no clock edge required.
- Read-after-write:
  - After the write edge, out shows the newly written value in the same cycle, because the read mux sees the updated register.
  - No write-through bypass before the edge: while load=1 and the edge has not yet occurred, out shows the old contents, not in.
- Address, in or load changing while clk is low, or between edges, has no effect on storage.
- All 3-bit address values are valid. There is no out-of-range case and no wrap logic.
- Power-up without reset: contents are undefined. The bench must pulse rst_n before checking reads.

Optional Feature:
- Macro: HACK_RAM8_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from in at write time.
  - Adds output port parity_err (1 bit). It is combinational and high when the stored parity of word[address] does not match the recomputed parity of its data.
  - Reset clears the parity bits to 0, which is consistent with all-zero data, so parity_err=0 after reset.
- Not defined: no parity storage and no parity_err port. The behaviour of out is identical in both builds.

Test Plan:
- Reset: pulse rst_n low with no clock edge -> out=0x0000 at every address 0..7.
- Sequential fill: with load=1, at addresses 0..7 write 0x0001..0x0008 on successive rising edges -> after each edge, out equals the value just written (address 3 reads 0x0004).
- Readback: load=0, in=0x0000, clock held low; step address 0..7 -> out = 0x0001..0x0008, each valid immediately with no clock edge.
- Hold: load=0, in=0xFFFF, address=5, apply 3 rising edges -> word5 still 0x0006; the other words are unchanged.
- Isolation and overwrite:
  - write 0xBEEF to address 2 -> address 2 reads 0xBEEF;
  - addresses 1 and 3 still read 0x0002 and 0x0004;
  - before the edge, with in=0xBEEF and load=1, address 2 still reads 0x0003.
- Async reset mid-operation: after the fill, drop rst_n between clock edges -> out goes to 0x0000 immediately; all words read 0 after release. A write edge while rst_n=0 is ignored.
